cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Run-control stage directly downstream of the slow-clock divider in the Frankenstein RISC-V FPGA build.
- Consumes the divider's slow square wave (slow_clk), a run switch, a step push-button and a halt request.
- Produces a single-cycle clock-enable pulse (cpu_ce) that advances the core on the fast system clock, plus a retired-cycle counter.
- Supports free-run, single-step, halt and cycle-count breakpoint, so the core never runs on a derived clock.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clk cycles required before the debounced button level changes (10 ms at 25 MHz).
- CNT_W, 32: width of cycle_count and bp_count.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- slow_clk  input  1  divider output; treated as asynchronous.
- run_sw  input  1  level; 1 = free-run requested. Treated as already synchronous.
- step_btn  input  1  raw mechanical push-button; 1 = pressed.
- halt_req  input  1  level, synchronous; forces HALT.
- bp_en  input  1  breakpoint enable.
- bp_count  input  CNT_W  cycle_count value at which RUN stops.
- cpu_ce  output  1  one-clk-wide core advance pulse.
- cycle_count  output  CNT_W  number of cpu_ce pulses issued since reset.
- state  output  2  encoding: 0 = HALT, 1 = RUN, 2 = STEP_ARMED, 3 = BREAK.
- running  output  1  high when state is RUN.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state = HALT; cpu_ce, cycle_count and running = 0.
  - Synchronizers, debounce counter and debounced level cleared.
  - Any pending step is cancelled.
  - This applies at any time, including mid-step.
- slow_clk path:
  - 2-flop synchronizer (s1, s2) plus previous-value flop.
  - tick = s2 & ~prev.
  - First posedge sampling slow_clk=1 is edge E; tick is high during the cycle after edge E+1; a granted cpu_ce is registered at edge E+2.
  - Exactly one tick per slow_clk rising edge.
- step_btn path:
  - 2-flop synchronizer.
  - Counter resets whenever the synced level equals the debounced level; when it reaches DEBOUNCE_CYCLES-1 with the levels differing, the debounced level flips.
  - step_press = one-cycle pulse on a debounced 0->1 transition. Releases generate nothing.
- cpu_ce:
  - Registered, high for exactly one clk cycle.
  - Issued only in response to a tick.
  - On each issued cpu_ce, cycle_count increments, wrapping mod 2^CNT_W.
- FSM, priority within each state is top to bottom:
  - HALT:
    - halt_req -> HALT.
    - Else run_sw=1 -> RUN.
    - Else step_press -> STEP_ARMED.
    - Ticks ignored.
  - RUN:
    - halt_req or run_sw=0 -> HALT; a coincident tick is suppressed (no cpu_ce).
    - Else on tick: issue cpu_ce. If bp_en=1 and cycle_count+1 == bp_count, go to BREAK after issuing (the pulse reaching bp_count is issued).
    - step_press ignored.
  - STEP_ARMED:
    - halt_req -> HALT with no cpu_ce.
    - Else on tick: issue one cpu_ce, then go to HALT regardless of run_sw.
    - Additional step_press ignored.
    - Breakpoint not evaluated.
  - BREAK:
    - No cpu_ce.
    - run_sw=0 or halt_req -> HALT.
    - step_press ignored.
- Breakpoint edge cases:
  - bp_en=1 with bp_count == cycle_count at RUN entry: no match until wrap.
  - bp_count changes take effect on the next tick.
- running = (state == RUN), registered with the state.

Test Plan:
- Reset, run_sw=1, slow_clk toggling every 8 clk -> first cpu_ce 3 edges after first slow_clk rise, one pulse per 16 clk; cycle_count = 5 after 5 rises; running=1.
- DEBOUNCE_CYCLES=4, HALT, step_btn bounces 1/0/1 at 1-cycle spacing then held high 10 cycles -> exactly one step_press, state=2, one cpu_ce on next tick, back to HALT, cycle_count=1.
- bp_en=1, bp_count=3, run_sw=1 from reset -> exactly 3 cpu_ce, state=3 (BREAK); run_sw=0 -> HALT; further ticks give no cpu_ce.
- RUN, assert halt_req in the same cycle as tick -> no cpu_ce, state=HALT next cycle, cycle_count unchanged.
- STEP_ARMED, then rst_n=0 for one cycle before the tick -> state=HALT, cycle_count=0, no cpu_ce from the later tick.
- CNT_W=4, run 17 ticks -> cycle_count wraps 15->0 and reads 1.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the board-side inputs/core and cpu_run_ctrl.
// master drives the controls and observes; slave is the run controller itself.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             slow_clk;
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
    logic             bp_en;
    logic [CNT_W-1:0] bp_count;
    logic             cpu_ce;
    logic [CNT_W-1:0] cycle_count;
    logic [1:0]       state;
    logic             running;

    modport master (
        output slow_clk, run_sw, step_btn, halt_req, bp_en, bp_count,
        input  cpu_ce, cycle_count, state, running
    );

    modport slave (
        input  slow_clk, run_sw, step_btn, halt_req, bp_en, bp_count,
        output cpu_ce, cycle_count, state, running
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: turns the slow divider square wave into single-cycle core
// clock enables, with free-run, single-step, halt and cycle-count breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_run_ctrl_if.slave bus
);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_STEP_ARMED = 2'd2,
        ST_BREAK      = 2'd3
    } state_e;

    logic            slow_s1_q,   slow_s1_d;
    logic            slow_s2_q,   slow_s2_d;
    logic            slow_prev_q, slow_prev_d;
    logic            btn_s1_q,    btn_s1_d;
    logic            btn_s2_q,    btn_s2_d;
    logic [DB_W-1:0] db_cnt_q,    db_cnt_d;
    logic            btn_db_q,    btn_db_d;
    logic            step_press_q, step_press_d;

    state_e           state_q,       state_d;
    logic             cpu_ce_q,      cpu_ce_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             running_q,     running_d;

    logic tick;
    logic bp_hit;

    // Synchronizers, slow_clk edge detect and step-button debounce
    always_comb begin
        slow_s1_d   = bus.slow_clk;
        slow_s2_d   = slow_s1_q;
        slow_prev_d = slow_s2_q;
        btn_s1_d    = bus.step_btn;
        btn_s2_d    = btn_s1_q;
        db_cnt_d    = db_cnt_q;
        btn_db_d    = btn_db_q;
        if (btn_s2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            btn_db_d = btn_s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        step_press_d = btn_db_d & ~btn_db_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slow_s1_q    <= 1'b0;
            slow_s2_q    <= 1'b0;
            slow_prev_q  <= 1'b0;
            btn_s1_q     <= 1'b0;
            btn_s2_q     <= 1'b0;
            db_cnt_q     <= '0;
            btn_db_q     <= 1'b0;
            step_press_q <= 1'b0;
        end else begin
            slow_s1_q    <= slow_s1_d;
            slow_s2_q    <= slow_s2_d;
            slow_prev_q  <= slow_prev_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            db_cnt_q     <= db_cnt_d;
            btn_db_q     <= btn_db_d;
            step_press_q <= step_press_d;
        end
    end

    assign tick   = slow_s2_q & ~slow_prev_q;
    // Compare against the post-increment count so a bp equal to the count at
    // RUN entry only matches after a full wrap.
    assign bp_hit = bus.bp_en && ((cycle_count_q + CNT_W'(1)) == bus.bp_count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_HALT;
            cpu_ce_q      <= 1'b0;
            cycle_count_q <= '0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_ce_q      <= cpu_ce_d;
            cycle_count_q <= cycle_count_d;
            running_q     <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HALT: begin
                if (bus.halt_req)      state_d = ST_HALT;
                else if (bus.run_sw)   state_d = ST_RUN;
                else if (step_press_q) state_d = ST_STEP_ARMED;
            end
            ST_RUN: begin
                if (bus.halt_req || !bus.run_sw) state_d = ST_HALT;
                else if (tick && bp_hit)         state_d = ST_BREAK;
            end
            ST_STEP_ARMED: begin
                if (bus.halt_req || tick) state_d = ST_HALT;
            end
            ST_BREAK: begin
                if (bus.halt_req || !bus.run_sw) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        cpu_ce_d = 1'b0;
        unique case (state_q)
            ST_RUN:        cpu_ce_d = tick && !bus.halt_req && bus.run_sw;
            ST_STEP_ARMED: cpu_ce_d = tick && !bus.halt_req;
            default:       cpu_ce_d = 1'b0;
        endcase
        cycle_count_d = cpu_ce_d ? (cycle_count_q + CNT_W'(1)) : cycle_count_q;
        running_d     = (state_d == ST_RUN);
    end

    assign bus.cpu_ce      = cpu_ce_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.state       = state_q;
    assign bus.running     = running_q;
endmodule
